// File: rtl/i2s_receiver.sv
// I2S serial-to-parallel receiver: one 24-bit left/right pair per frame with a one-cycle valid strobe.
// Optional macro I2S_RX_SYNC_EN adds a two-flop synchronizer on sclk, lrclk and sdin (+2 mclk latency).
module i2s_receiver #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              lrclk,
  input  logic              sdin,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + SLOT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PAD_MAX  = CNT_W'(SLOT_W - DATA_W + 1);

  typedef enum logic [1:0] {S_SYNC, S_SHIFT, S_PAD} state_t;

  logic w_sclk;
  logic w_lrclk;
  logic w_sdin;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] r_sclk_s;
  logic [1:0] r_lrclk_s;
  logic [1:0] r_sdin_s;

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_sclk_s  <= '0;
      r_lrclk_s <= '0;
      r_sdin_s  <= '0;
    end else begin
      r_sclk_s  <= {r_sclk_s[0], sclk};
      r_lrclk_s <= {r_lrclk_s[0], lrclk};
      r_sdin_s  <= {r_sdin_s[0], sdin};
    end
  end

  assign w_sclk  = r_sclk_s[1];
  assign w_lrclk = r_lrclk_s[1];
  assign w_sdin  = r_sdin_s[1];
`else
  assign w_sclk  = sclk;
  assign w_lrclk = lrclk;
  assign w_sdin  = sdin;
`endif

  state_t            r_state;
  logic              r_sclk_q;
  logic              r_lrclk_prev;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_chan;
  logic              r_left_ok;

  logic              w_rise;
  logic              w_chg;
  logic [DATA_W-1:0] w_word;

  assign w_rise = w_sclk & ~r_sclk_q;
  assign w_chg  = w_lrclk ^ r_lrclk_prev;
  assign w_word = {r_shift[DATA_W-2:0], w_sdin};

  // r_left_ok marks a hold register filled by a fully received left word of the current frame.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state      <= S_SYNC;
      r_sclk_q     <= 1'b0;
      r_lrclk_prev <= 1'b0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_cnt        <= '0;
      r_chan       <= 1'b0;
      r_left_ok    <= 1'b0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_sclk_q     <= w_sclk;
      sample_valid <= 1'b0;
      if (w_rise) begin
        r_lrclk_prev <= w_lrclk;
        unique case (r_state)
          S_SYNC: begin
            if (w_chg && !w_lrclk) begin
              r_cnt     <= '0;
              r_chan    <= 1'b0;
              r_left_ok <= 1'b0;
              r_state   <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (w_chg) begin
              // Short slot: drop the partial word and restart on the new channel.
              frame_err <= 1'b1;
              r_cnt     <= '0;
              r_chan    <= w_lrclk;
              if (!w_lrclk) r_left_ok <= 1'b0;
            end else begin
              r_shift <= w_word;
              if (r_cnt == LAST_BIT) begin
                r_cnt   <= '0;
                r_state <= S_PAD;
                if (!r_chan) begin
                  r_hold    <= w_word;
                  r_left_ok <= 1'b1;
                end else if (r_left_ok) begin
                  left_data    <= r_hold;
                  right_data   <= w_word;
                  sample_valid <= 1'b1;
                  r_left_ok    <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          S_PAD: begin
            if (w_chg) begin
              if (r_chan == w_lrclk) frame_err <= 1'b1;
              r_cnt   <= '0;
              r_chan  <= w_lrclk;
              if (!w_lrclk) r_left_ok <= 1'b0;
              r_state <= S_SHIFT;
            end else if (r_cnt >= PAD_MAX) begin
              frame_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomized scoreboard bench for i2s_receiver: serializes I2S frames and checks received pairs in order.
module tb_i2s_receiver;

  localparam int DATA_W = 24;
  localparam int SLOT_W = 32;
  localparam int HALF   = 4;

  logic              mclk = 1'b0;
  logic              rst;
  logic              sclk;
  logic              lrclk;
  logic              sdin;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              sample_valid;
  logic              frame_err;

  i2s_receiver #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
    .mclk(mclk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdin(sdin),
    .left_data(left_data), .right_data(right_data),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One sclk period: data and word select change while sclk is low, receiver samples on the rise.
  task automatic drive_bit(input logic lr, input logic d);
    @(negedge mclk);
    sclk  = 1'b0;
    lrclk = lr;
    sdin  = d;
    repeat (HALF) @(negedge mclk);
    sclk = 1'b1;
    repeat (HALF - 1) @(negedge mclk);
  endtask

  function automatic logic pad_bit(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom);
  endfunction

  // Slot layout: one delay bit, ndata MSB-first data bits, then padding up to SLOT_W (full slots only).
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w, input int ndata, input int mode);
    drive_bit(lr, pad_bit(mode));
    for (int i = 0; i < ndata; i++) drive_bit(lr, w[DATA_W-1-i]);
    if (ndata == DATA_W)
      for (int i = 0; i < SLOT_W - 1 - DATA_W; i++) drive_bit(lr, pad_bit(mode));
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int mode);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
    send_slot(1'b0, l, DATA_W, mode);
    send_slot(1'b1, r, DATA_W, mode);
  endtask

  // Monitor: every valid strobe must match the oldest outstanding expected pair.
  always @(posedge mclk) begin
    pair_t p;
    #1;
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        p = exp_q.pop_front();
        chk("left_data", 32'(left_data), 32'(p.l));
        chk("right_data", 32'(right_data), 32'(p.r));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] vals [5];
    vals[0] = 24'd34245;
    vals[1] = 24'd12312;
    vals[2] = 24'h8A01D0;
    vals[3] = 24'd0;
    vals[4] = 24'hFFFFFF;

    rst   = 1'b1;
    sclk  = 1'b0;
    lrclk = 1'b1;
    sdin  = 1'b0;

    // Reset held while sclk toggles inside a right slot.
    for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'($urandom));
    chk("rst_left", 32'(left_data), 32'd0);
    chk("rst_right", 32'(right_data), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) drive_bit(1'b1, 1'($urandom));

    send_frame(24'h00C491, 24'h000853, 0);
    chk("err_after_single", 32'(frame_err), 32'd0);

    for (int i = 0; i < 5; i++) send_frame(vals[i], vals[(i + 1) % 5], 0);

    send_frame(24'h800000, 24'h7FFFFF, 1);

    for (int i = 0; i < 6; i++) send_frame(24'($urandom), 24'($urandom), 2);
    chk("err_clean_run", 32'(frame_err), 32'd0);

    // Left slot cut after 10 bits: that pair must not be output.
    send_slot(1'b0, 24'($urandom), 10, 2);
    send_slot(1'b1, 24'($urandom), DATA_W, 2);
    chk("err_short_slot", 32'(frame_err), 32'd1);

    send_frame(24'($urandom), 24'($urandom), 2);
    send_frame(24'h123456, 24'hABCDEF, 2);
    chk("err_sticky", 32'(frame_err), 32'd1);

    repeat (40) @(negedge mclk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
